// File: rtl/i2c_regfile_slave.sv
// I2C slave exposing a byte-wide register file: NUM_RW read/write registers
// followed by NUM_RO read-only registers, with a register pointer that
// auto-increments (and wraps) across burst reads and writes.
//
// Write-side output semantics: wr_strobe is a single-cycle qualifier for
// wr_index; there is no backpressure. The written byte is already visible in
// rw_data during the strobe cycle.
module i2c_regfile_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h57,
    parameter int         NUM_RW     = 4,
    parameter int         NUM_RO     = 2,
    parameter logic [7:0] RESET_VAL  = 8'h00,
    localparam int        NREG       = NUM_RW + NUM_RO,
    localparam int        PW         = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int        ROW        = (NUM_RO > 0) ? 8 * NUM_RO : 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scl,
    inout  wire                 sda,
    input  logic [ROW-1:0]      ro_data,
    output logic [8*NUM_RW-1:0] rw_data,
    output logic                wr_strobe,
    output logic [PW-1:0]       wr_index,
    output logic [3:0]          debug_state
);

    localparam logic [3:0] IDLE         = 4'd0;
    localparam logic [3:0] RX_DEV_ADDR  = 4'd1;
    localparam logic [3:0] DEV_ADDR_ACK = 4'd2;
    localparam logic [3:0] RX_PTR       = 4'd3;
    localparam logic [3:0] PTR_ACK      = 4'd4;
    localparam logic [3:0] RX_DATA      = 4'd5;
    localparam logic [3:0] DATA_ACK     = 4'd6;
    localparam logic [3:0] TX_DATA      = 4'd7;
    localparam logic [3:0] TX_ACK       = 4'd8;
    localparam logic [3:0] WAIT_STOP    = 4'd9;

    logic [2:0]    scl_sync;
    logic [2:0]    sda_sync;
    logic [3:0]    state;
    logic [2:0]    bit_count;
    logic [7:0]    shift;
    logic [PW-1:0] ptr;
    logic [7:0]    rw_regs [NUM_RW];
    logic          sda_oe;
    logic          ack_on;   // first half of an ACK slot seen (slave) / master ACK seen (TX)
    logic          rd_mode;

    logic          sda_in;
    logic          scl_rise;
    logic          scl_fall;
    logic          start_det;
    logic          stop_det;
    logic [7:0]    rx_byte;
    logic          ptr_is_rw;
    logic [PW-1:0] next_ptr;
    logic [7:0]    tx_byte;

    // Open-drain pad: only ever pull low or release.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Bus synchronisers; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl};
            sda_sync <= {sda_sync[1:0], sda};
        end
    end

    assign sda_in    = sda_sync[1];
    assign scl_rise  = scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] & scl_sync[2];
    assign start_det = scl_sync[1] & scl_sync[2] & sda_sync[2] & ~sda_sync[1];
    assign stop_det  = scl_sync[1] & scl_sync[2] & ~sda_sync[2] & sda_sync[1];

    assign rx_byte   = {shift[6:0], sda_in};
    assign ptr_is_rw = ({1'b0, ptr} < (PW + 1)'(NUM_RW));
    assign next_ptr  = (ptr == PW'(NREG - 1)) ? '0 : ptr + 1'b1;

    // Read mux over the whole register map (RW first, then RO inputs).
    always_comb begin
        tx_byte = 8'h00;
        for (int k = 0; k < NUM_RW; k++) begin
            if (ptr == PW'(k)) tx_byte = rw_regs[k];
        end
        for (int k = 0; k < NUM_RO; k++) begin
            if (ptr == PW'(NUM_RW + k)) tx_byte = ro_data[8*k +: 8];
        end
    end

    // Protocol FSM: STOP beats START beats per-state bit handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_count <= 3'd0;
            shift     <= 8'h00;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            ack_on    <= 1'b0;
            rd_mode   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            for (int k = 0; k < NUM_RW; k++) rw_regs[k] <= RESET_VAL;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
            end else if (start_det) begin
                state     <= RX_DEV_ADDR;
                bit_count <= 3'd0;
                sda_oe    <= 1'b0;
                ack_on    <= 1'b0;
            end else begin
                case (state)
                    RX_DEV_ADDR: if (scl_rise) begin
                        shift     <= rx_byte;
                        bit_count <= bit_count + 3'd1;
                        if (bit_count == 3'd7) begin
                            if (shift[6:0] == SLAVE_ADDR) begin
                                rd_mode <= sda_in;
                                state   <= DEV_ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    DEV_ADDR_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            sda_oe <= 1'b1;
                            ack_on <= 1'b1;
                        end else begin
                            ack_on    <= 1'b0;
                            bit_count <= 3'd0;
                            if (rd_mode) begin
                                // Load first byte and present its MSB on this same edge.
                                shift  <= tx_byte;
                                sda_oe <= ~tx_byte[7];
                                ptr    <= next_ptr;
                                state  <= TX_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= RX_PTR;
                            end
                        end
                    end
                    RX_PTR: if (scl_rise) begin
                        shift     <= rx_byte;
                        bit_count <= bit_count + 3'd1;
                        if (bit_count == 3'd7) begin
                            if ({1'b0, rx_byte} < 9'(NREG)) begin
                                ptr   <= rx_byte[PW-1:0];
                                state <= PTR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    PTR_ACK, DATA_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            sda_oe <= 1'b1;
                            ack_on <= 1'b1;
                        end else begin
                            ack_on    <= 1'b0;
                            sda_oe    <= 1'b0;
                            bit_count <= 3'd0;
                            state     <= RX_DATA;
                        end
                    end
                    RX_DATA: if (scl_rise) begin
                        shift     <= rx_byte;
                        bit_count <= bit_count + 3'd1;
                        if (bit_count == 3'd7) begin
                            // RO targets are acknowledged but the byte is dropped.
                            if (ptr_is_rw) begin
                                for (int k = 0; k < NUM_RW; k++) begin
                                    if (ptr == PW'(k)) rw_regs[k] <= rx_byte;
                                end
                                wr_strobe <= 1'b1;
                                wr_index  <= ptr;
                            end
                            ptr   <= next_ptr;
                            state <= DATA_ACK;
                        end
                    end
                    TX_DATA: if (scl_fall) begin
                        if (bit_count == 3'd7) begin
                            sda_oe <= 1'b0;
                            state  <= TX_ACK;
                        end else begin
                            shift     <= {shift[6:0], shift[7]};
                            sda_oe    <= ~shift[6];
                            bit_count <= bit_count + 3'd1;
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_in) state <= WAIT_STOP;
                            else        ack_on <= 1'b1;
                        end else if (scl_fall && ack_on) begin
                            ack_on    <= 1'b0;
                            shift     <= tx_byte;
                            sda_oe    <= ~tx_byte[7];
                            ptr       <= next_ptr;
                            bit_count <= 3'd0;
                            state     <= TX_DATA;
                        end
                    end
                    IDLE, WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUM_RW; k++) begin : g_rw_out
        assign rw_data[8*k +: 8] = rw_regs[k];
    end

    assign debug_state = state;

endmodule

// File: tb/tb_i2c_regfile_slave.sv
// Bench for i2c_regfile_slave: a bit-banged I2C master drives directed frames;
// expected ACK bits / read bytes and expected write strobes go into queues that
// independent monitors pop when the bus or the DUT presents a result.
module tb_i2c_regfile_slave;

    localparam int Q = 10;   // clk cycles per quarter SCL period
    localparam int W = 9;    // {is_data_byte, value[7:0]}

    logic        clk = 1'b0;
    logic        rst;
    logic        scl;
    logic        m_sda_low;
    wire         sda;
    logic [15:0] ro_data;
    logic [31:0] rw_data;
    logic        wr_strobe;
    logic [2:0]  wr_index;
    logic [3:0]  debug_state;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_regfile_slave dut (
        .clk         (clk),
        .rst         (rst),
        .scl         (scl),
        .sda         (sda),
        .ro_data     (ro_data),
        .rw_data     (rw_data),
        .wr_strobe   (wr_strobe),
        .wr_index    (wr_index),
        .debug_state (debug_state)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]  exp_q[$];
    logic [10:0]   stb_q[$];
    logic          obs_valid = 1'b0;
    logic [W-1:0]  obs_val;
    logic [W-1:0]  bus_exp;
    logic [10:0]   stb_exp;
    logic [10:0]   stb_got;
    int            stb_idx;
    logic          slave_drove;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus scoreboard: ACK bits and bytes read by the master.
    always @(posedge clk) begin
        if (obs_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL bus_unexpected: got %h expected nothing", obs_val);
            end else begin
                bus_exp = exp_q.pop_front();
                if (obs_val !== bus_exp) begin
                    n_fail++;
                    $display("FAIL bus_response: got %h expected %h", obs_val, bus_exp);
                end
            end
        end
    end

    // Write-strobe scoreboard: {wr_index, written byte as seen on rw_data}.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            stb_idx = int'(wr_index);
            stb_got = {wr_index, rw_data[stb_idx*8 +: 8]};
            n_checks++;
            if (stb_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_strobe_unexpected: got %h expected nothing", stb_got);
            end else begin
                stb_exp = stb_q.pop_front();
                if (stb_got !== stb_exp) begin
                    n_fail++;
                    $display("FAIL wr_strobe: got %h expected %h", stb_got, stb_exp);
                end
            end
        end
    end

    // Flags any low level on SDA not caused by the master.
    always @(negedge clk) begin
        if (sda === 1'b0 && !m_sda_low) slave_drove = 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_q;
        repeat (Q) @(negedge clk);
    endtask

    task automatic post_obs(input logic [W-1:0] v);
        obs_val   = v;
        obs_valid = 1'b1;
        @(posedge clk);
        #1 obs_valid = 1'b0;
    endtask

    task automatic bit_out(input logic b);
        m_sda_low = ~b;
        wait_q; scl = 1'b1;
        wait_q; wait_q; scl = 1'b0;
        wait_q;
    endtask

    task automatic bit_in(output logic b);
        m_sda_low = 1'b0;
        wait_q; scl = 1'b1;
        wait_q; b = (sda === 1'b0) ? 1'b0 : 1'b1;
        wait_q; scl = 1'b0;
        wait_q;
    endtask

    task automatic i2c_start;
        m_sda_low = 1'b0;
        wait_q; scl = 1'b1;
        wait_q; m_sda_low = 1'b1;
        wait_q; scl = 1'b0;
        wait_q;
    endtask

    task automatic i2c_stop;
        m_sda_low = 1'b1;
        wait_q; scl = 1'b1;
        wait_q; m_sda_low = 1'b0;
        wait_q; wait_q;
    endtask

    // exp_nack: 0 = slave should ACK, 1 = slave should not.
    task automatic send_byte(input logic [7:0] d, input logic exp_nack);
        logic a;
        exp_q.push_back({1'b0, 7'd0, exp_nack});
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(a);
        post_obs({1'b0, 7'd0, a});
    endtask

    task automatic recv_byte(input logic [7:0] exp_d, input logic master_ack);
        logic [7:0] d;
        logic       b;
        exp_q.push_back({1'b1, exp_d});
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_in(b);
            d = {d[6:0], b};
        end
        post_obs({1'b1, d});
        bit_out(master_ack ? 1'b0 : 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; scl = 1'b1; m_sda_low = 1'b0; ro_data = {8'h22, 8'h11};
        slave_drove = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_state", debug_state, 32'd0);
        check("reset_rw_data", rw_data, 32'h0);
        check("reset_wr_strobe", wr_strobe, 32'd0);
        check("reset_wr_index", wr_index, 32'd0);
        check("reset_sda_released", sda === 1'b0, 32'd0);

        // 1: burst write to regs 1,2
        i2c_start;
        send_byte(8'hAE, 1'b0);
        send_byte(8'h01, 1'b0);
        stb_q.push_back({3'd1, 8'h5A});
        send_byte(8'h5A, 1'b0);
        stb_q.push_back({3'd2, 8'hC3});
        send_byte(8'hC3, 1'b0);
        i2c_stop;
        check("t1_state_idle", debug_state, 32'd0);
        check("t1_rw_data", rw_data, 32'h00C35A00);

        // Setup: reg3 = E7; then write via RO reg 5 (dropped) wrapping to reg0 = 3C
        i2c_start;
        send_byte(8'hAE, 1'b0);
        send_byte(8'h03, 1'b0);
        stb_q.push_back({3'd3, 8'hE7});
        send_byte(8'hE7, 1'b0);
        i2c_stop;
        i2c_start;
        send_byte(8'hAE, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h99, 1'b0);
        stb_q.push_back({3'd0, 8'h3C});
        send_byte(8'h3C, 1'b0);
        i2c_stop;
        check("wrap_write_rw_data", rw_data, 32'hE7C35A3C);

        // 2: set pointer 3, repeated START, burst read across RW/RO boundary
        i2c_start;
        send_byte(8'hAE, 1'b0);
        send_byte(8'h03, 1'b0);
        i2c_start;
        send_byte(8'hAF, 1'b0);
        recv_byte(8'hE7, 1'b1);
        recv_byte(8'h11, 1'b1);
        recv_byte(8'h22, 1'b0);
        i2c_stop;
        check("t2_state_idle", debug_state, 32'd0);
        // pointer wrapped past index 5 to 0
        i2c_start;
        send_byte(8'hAF, 1'b0);
        recv_byte(8'h3C, 1'b0);
        i2c_stop;

        // 3: foreign address, slave must stay off the bus
        slave_drove = 1'b0;
        i2c_start;
        send_byte(8'hA0, 1'b1);
        send_byte(8'h00, 1'b1);
        check("t3_wait_stop", debug_state, 32'd9);
        i2c_stop;
        check("t3_state_idle", debug_state, 32'd0);
        check("t3_sda_never_driven", slave_drove, 32'd0);

        // 4: out-of-range pointer NACKed, pointer kept (was 1 after the wrap read)
        i2c_start;
        send_byte(8'hAE, 1'b0);
        send_byte(8'h06, 1'b1);
        check("t4_wait_stop", debug_state, 32'd9);
        i2c_stop;
        check("t4_rw_data", rw_data, 32'hE7C35A3C);
        i2c_start;
        send_byte(8'hAF, 1'b0);
        recv_byte(8'h5A, 1'b0);
        i2c_stop;

        // 5: write to RO register is ACKed but ignored; read it back
        i2c_start;
        send_byte(8'hAE, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'hFF, 1'b0);
        i2c_stop;
        check("t5_rw_data", rw_data, 32'hE7C35A3C);
        i2c_start;
        send_byte(8'hAE, 1'b0);
        send_byte(8'h04, 1'b0);
        i2c_start;
        send_byte(8'hAF, 1'b0);
        recv_byte(8'h11, 1'b0);
        i2c_stop;

        // 6: reset while the slave holds the address ACK
        i2c_start;
        for (int i = 7; i >= 0; i--) bit_out(1'(8'hAE >> i));
        m_sda_low = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_ack_driven", sda === 1'b0, 32'd1);
        check("t6_state_addr_ack", debug_state, 32'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_sda_released", sda === 1'b0, 32'd0);
        check("t6_state_idle", debug_state, 32'd0);
        check("t6_rw_reset", rw_data, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        i2c_stop;
        i2c_start;
        send_byte(8'hAE, 1'b0);
        send_byte(8'h00, 1'b0);
        stb_q.push_back({3'd0, 8'h77});
        send_byte(8'h77, 1'b0);
        i2c_stop;
        check("t6_rw_after", rw_data, 32'h00000077);
        i2c_start;
        send_byte(8'hAE, 1'b0);
        send_byte(8'h00, 1'b0);
        i2c_start;
        send_byte(8'hAF, 1'b0);
        recv_byte(8'h77, 1'b0);
        i2c_stop;

        repeat (10) @(negedge clk);
        check("bus_queue_drained", exp_q.size(), 32'd0);
        check("strobe_queue_drained", stb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
